// File: rtl/mul_seq_ctrl_pkg.sv
// Shared EX-stage definitions: ALU opcodes and the multiply sequencer state
// encoding. The ALU, ALU control and EX arbiter import the same constants.
package mul_seq_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_GT  = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Value of the iteration counter on the last of the 32 iterations.
   localparam logic [5:0] MUL_LAST_CNT = 6'd31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ITER  = 2'b01,
      ST_CARRY = 2'b10,
      ST_DONE  = 2'b11
   } mul_state_t;

   // The sequencer reports busy while it is iterating or resolving a carry.
   function automatic logic is_busy_state(input mul_state_t s);
      return (s == ST_ITER) || (s == ST_CARRY);
   endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Unsigned shift-add multiplier that borrows the EX-stage ALU through a
// req/gnt handshake. An add takes two ALU cycles: ADD forms the partial sum,
// then a GT compare (hi > sum) recovers the carry-out, so no local adder is
// needed. A refused grant freezes every register for that cycle.
module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out
);

   mul_state_t       state_r, next_state_s;
   logic [WIDTH-1:0] mcand_r, mcand_next_s;
   logic [WIDTH-1:0] tmp_r,   tmp_next_s;
   logic [WIDTH-1:0] hi_r,    hi_next_s;
   logic [WIDTH-1:0] lo_r,    lo_next_s;
   logic [5:0]       cnt_r,   cnt_next_s;
   logic             busy_r;
   logic             done_r;

   // Next-state, datapath updates and ALU request decode.
   always_comb begin
      next_state_s = state_r;
      mcand_next_s = mcand_r;
      tmp_next_s   = tmp_r;
      hi_next_s    = hi_r;
      lo_next_s    = lo_r;
      cnt_next_s   = cnt_r;
      alu_req      = 1'b0;
      alu_op       = ALU_AND;
      alu_a        = {WIDTH{1'b0}};
      alu_b        = {WIDTH{1'b0}};

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               mcand_next_s = multiplicand;
               lo_next_s    = multiplier;
               hi_next_s    = {WIDTH{1'b0}};
               cnt_next_s   = 6'd0;
               next_state_s = ST_ITER;
            end else begin
               next_state_s = ST_IDLE;
            end
         end

         ST_ITER: begin
            if (lo_r[0] == 1'b0) begin
               // Zero multiplier bit: plain shift, the ALU is not needed.
               hi_next_s  = {1'b0, hi_r[WIDTH-1:1]};
               lo_next_s  = {hi_r[0], lo_r[WIDTH-1:1]};
               cnt_next_s = cnt_r + 6'd1;
               if (cnt_r == MUL_LAST_CNT) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_ITER;
               end
            end else begin
               alu_req = 1'b1;
               alu_op  = ALU_ADD;
               alu_a   = hi_r;
               alu_b   = mcand_r;
               if (alu_gnt) begin
                  tmp_next_s   = alu_out;
                  next_state_s = ST_CARRY;
               end else begin
                  next_state_s = ST_ITER;
               end
            end
         end

         ST_CARRY: begin
            // hi > sum (unsigned) exactly when the add wrapped.
            alu_req = 1'b1;
            alu_op  = ALU_GT;
            alu_a   = hi_r;
            alu_b   = tmp_r;
            if (alu_gnt) begin
               hi_next_s  = {alu_out[0], tmp_r[WIDTH-1:1]};
               lo_next_s  = {tmp_r[0], lo_r[WIDTH-1:1]};
               cnt_next_s = cnt_r + 6'd1;
               if (cnt_r == MUL_LAST_CNT) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_ITER;
               end
            end else begin
               next_state_s = ST_CARRY;
            end
         end

         ST_DONE: begin
            next_state_s = ST_IDLE;
         end

         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and status registers; reset aborts any multiply.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         mcand_r <= {WIDTH{1'b0}};
         tmp_r   <= {WIDTH{1'b0}};
         hi_r    <= {WIDTH{1'b0}};
         lo_r    <= {WIDTH{1'b0}};
         cnt_r   <= 6'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         mcand_r <= mcand_next_s;
         tmp_r   <= tmp_next_s;
         hi_r    <= hi_next_s;
         lo_r    <= lo_next_s;
         cnt_r   <= cnt_next_s;
         busy_r  <= is_busy_state(next_state_s);
         done_r  <= (next_state_s == ST_DONE);
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. Models the external ALU, drives the
// grant, and compares against 64-bit arithmetic and the cycle-count rule
// busy = 32 + popcount(multiplier) + refused grants.
module tb_mul_seq_ctrl;
   import mul_seq_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        alu_req;
   logic        alu_gnt;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;

   int vectors    = 0;
   int miscompares = 0;
   int last_busy;
   int last_req;

   mul_seq_ctrl #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .hi           (hi),
      .lo           (lo),
      .alu_req      (alu_req),
      .alu_gnt      (alu_gnt),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_out      (alu_out)
   );

   always #5 clk = ~clk;

   // Behavioural EX-stage ALU.
   always_comb begin
      case (alu_op)
         4'b0000: alu_out = alu_a & alu_b;
         4'b0001: alu_out = alu_a | alu_b;
         4'b0010: alu_out = alu_a + alu_b;
         4'b0110: alu_out = alu_a - alu_b;
         4'b0111: alu_out = (alu_a > alu_b) ? 32'd1 : 32'd0;
         4'b1100: alu_out = ~(alu_a | alu_b);
         default: alu_out = 32'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One multiply from IDLE to the cycle after done. stall_pct refuses that
   // share of ALU requests at random; carry_hold refuses the first CARRY
   // request that many times; restart_at pulses start on that busy cycle.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input int stall_pct, input int carry_hold, input int restart_at);
      int          busy_cycles;
      int          stalls;
      int          req_cycles;
      int          hold_left;
      logic        hold_done;
      logic        prev_stall;
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      logic [31:0] exp_tmp;
      logic [63:0] prod;

      prod = {32'd0, a} * {32'd0, b};
      busy_cycles = 0;
      stalls      = 0;
      req_cycles  = 0;
      hold_left   = carry_hold;
      hold_done   = 1'b0;
      prev_stall  = 1'b0;
      prev_hi     = 32'd0;
      prev_lo     = 32'd0;
      exp_tmp     = 32'd0;

      @(negedge clk);
      start = 1'b1; multiplicand = a; multiplier = b; alu_gnt = 1'b1;
      @(negedge clk);
      start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
      chk("busy_after_start", {63'd0, busy}, 64'd1);

      while (busy === 1'b1 && busy_cycles < 400) begin
         busy_cycles++;
         if (prev_stall) begin
            chk("hold_hi", {32'd0, hi}, {32'd0, prev_hi});
            chk("hold_lo", {32'd0, lo}, {32'd0, prev_lo});
         end
         chk("done_low_while_busy", {63'd0, done}, 64'd0);
         start = (busy_cycles == restart_at);
         if (start) begin
            multiplicand = 32'd99;
            multiplier   = 32'd99;
         end
         if (alu_req === 1'b1) begin
            req_cycles++;
            chk("alu_a", {32'd0, alu_a}, {32'd0, hi});
            if (alu_op === ALU_ADD) begin
               chk("alu_b_add", {32'd0, alu_b}, {32'd0, a});
            end else if (alu_op === ALU_GT) begin
               chk("alu_b_gt", {32'd0, alu_b}, {32'd0, exp_tmp});
            end else begin
               chk("alu_op_busy", {60'd0, alu_op}, {60'd0, ALU_ADD});
            end
            alu_gnt = 1'b1;
            if (alu_op === ALU_GT && !hold_done) begin
               if (hold_left > 0) begin
                  alu_gnt = 1'b0;
                  hold_left--;
               end else begin
                  hold_done = 1'b1;
               end
            end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
               alu_gnt = 1'b0;
            end
            if (!alu_gnt) stalls++;
            else if (alu_op === ALU_ADD) exp_tmp = hi + a;
            prev_stall = !alu_gnt;
            prev_hi    = hi;
            prev_lo    = lo;
         end else begin
            chk("alu_op_idle", {60'd0, alu_op}, 64'd0);
            chk("alu_ab_idle", {alu_a, alu_b}, 64'd0);
            alu_gnt    = 1'($urandom_range(1));
            prev_stall = 1'b0;
         end
         @(negedge clk);
      end

      start   = 1'b0;
      alu_gnt = 1'b1;
      chk("busy_cycles", 64'(busy_cycles), 64'(32 + $countones(b) + stalls));
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("product", {hi, lo}, prod);

      // start during DONE must be ignored.
      start = 1'b1; multiplicand = $urandom; multiplier = $urandom;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
      chk("product_hold", {hi, lo}, prod);

      last_busy = busy_cycles;
      last_req  = req_cycles;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; alu_gnt = 1'b1;
      multiplicand = 32'd0; multiplier = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_req",  {63'd0, alu_req}, 64'd0);
      chk("rst_op",   {60'd0, alu_op}, 64'd0);
      chk("rst_ab",   {alu_a, alu_b}, 64'd0);
      reset = 1'b0;

      run_mul(32'd3, 32'd5, 0, 0, 0);
      chk("busy_3x5", 64'(last_busy), 64'd34);

      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      chk("busy_ffxff", 64'(last_busy), 64'd64);

      run_mul(32'h1234_5678, 32'd0, 0, 0, 0);
      chk("busy_zero", 64'(last_busy), 64'd32);
      chk("no_req_zero", 64'(last_req), 64'd0);

      run_mul(32'd7, 32'd1, 0, 5, 0);
      chk("busy_7x1_hold", 64'(last_busy), 64'd38);

      run_mul(32'd3, 32'd5, 0, 0, 10);
      chk("busy_3x5_restart", 64'(last_busy), 64'd34);

      // Reset in the middle of a multiply.
      @(negedge clk);
      start = 1'b1; multiplicand = 32'd3; multiplier = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      chk("abort_req",  {63'd0, alu_req}, 64'd0);
      chk("abort_ab",   {alu_a, alu_b}, 64'd0);

      run_mul(32'd2, 32'd9, 0, 0, 0);
      chk("after_abort_lo", {32'd0, lo}, 64'd18);

      for (int i = 0; i < 6; i++) begin
         run_mul($urandom, $urandom, (i % 2 == 1) ? 30 : 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
